// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode encodings and the entry layout for the ALU reservation station.
// Also holds the CDB snoop helper used by both the dispatch bypass and the wakeup paths.
package reservation_station_pkg;

  localparam int RS_SIZE = 16;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int CNT_W   = IDX_W + 1;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
  localparam logic [OP_W-1:0] OP_AND  = 6'd3;
  localparam logic [OP_W-1:0] OP_OR   = 6'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd5;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd9;
  localparam logic [OP_W-1:0] OP_SLTU = 6'd10;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  tag;
    logic              q1_busy;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] v1;
    logic              q2_busy;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v2;
  } rs_entry_t;

  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] val;
  } operand_t;

  // Resolve one operand against both CDBs; the ALU broadcast takes precedence.
  function automatic operand_t snoop(
    input logic              q_busy,
    input logic [TAG_W-1:0]  q,
    input logic [DATA_W-1:0] v,
    input logic              alu_vld,
    input logic [TAG_W-1:0]  alu_tag,
    input logic [DATA_W-1:0] alu_dat,
    input logic              lsb_vld,
    input logic [TAG_W-1:0]  lsb_tag,
    input logic [DATA_W-1:0] lsb_dat
  );
    operand_t r;
    r.busy = q_busy;
    r.val  = v;
    if (q_busy) begin
      if (alu_vld && (alu_tag == q)) begin
        r.busy = 1'b0;
        r.val  = alu_dat;
      end else if (lsb_vld && (lsb_tag == q)) begin
        r.busy = 1'b0;
        r.val  = lsb_dat;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_priority_sel.sv
// Lowest-index request encoder: returns the index of the lowest set bit and whether any bit is set.
// Purely combinational, zero latency.
module rs_priority_sel #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan downwards so the lowest set bit is the last one to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: captures operands from both CDBs and issues the lowest ready entry per cycle.
// Issue is registered (ready entry -> alu_valid one edge later); dispatch is dropped while full.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_imm,
  input  logic [DATA_W-1:0] disp_pc,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic              disp_q1_busy,
  input  logic [TAG_W-1:0]  disp_q1,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic              disp_q2_busy,
  input  logic [TAG_W-1:0]  disp_q2,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic              cdb_alu_valid,
  input  logic [TAG_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_data,
  input  logic              cdb_lsb_valid,
  input  logic [TAG_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_data,
  output logic              full,
  output logic              alu_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_v1,
  output logic [DATA_W-1:0] alu_v2,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_pc,
  output logic [TAG_W-1:0]  alu_tag
);

  rs_entry_t         entries_q [RS_SIZE];
  rs_entry_t         entries_d [RS_SIZE];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              alu_valid_q, alu_valid_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_v1_q, alu_v1_d;
  logic [DATA_W-1:0] alu_v2_q, alu_v2_d;
  logic [DATA_W-1:0] alu_imm_q, alu_imm_d;
  logic [DATA_W-1:0] alu_pc_q, alu_pc_d;
  logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;

  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic [IDX_W-1:0]   free_idx, ready_idx;
  logic               free_any, ready_any;
  logic               accept;
  operand_t           op1, op2;
  rs_entry_t          new_entry;

  // Readiness is judged purely on registered state, so a wakeup never issues in its own cycle.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = !entries_q[i].busy;
      ready_vec[i] = entries_q[i].busy && !entries_q[i].q1_busy && !entries_q[i].q2_busy;
    end
  end

  rs_priority_sel #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
    .req (free_vec),
    .idx (free_idx),
    .any (free_any)
  );

  rs_priority_sel #(.N(RS_SIZE), .W(IDX_W)) u_ready_sel (
    .req (ready_vec),
    .idx (ready_idx),
    .any (ready_any)
  );

  // free_any tracks the busy count exactly, so it is the same condition as !full.
  assign accept = disp_valid && free_any;

  always_comb begin
    op1 = snoop(disp_q1_busy, disp_q1, disp_v1,
                cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
    op2 = snoop(disp_q2_busy, disp_q2, disp_v2,
                cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
    new_entry         = '0;
    new_entry.busy    = 1'b1;
    new_entry.op      = disp_op;
    new_entry.imm     = disp_imm;
    new_entry.pc      = disp_pc;
    new_entry.tag     = disp_tag;
    new_entry.q1_busy = op1.busy;
    new_entry.q1      = disp_q1;
    new_entry.v1      = op1.val;
    new_entry.q2_busy = op2.busy;
    new_entry.q2      = disp_q2;
    new_entry.v2      = op2.val;
  end

  always_comb begin
    operand_t w1, w2;
    entries_d   = entries_q;
    count_d     = count_q;
    full_d      = full_q;
    alu_valid_d = 1'b0;
    alu_op_d    = OP_NOP;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;
    alu_imm_d   = alu_imm_q;
    alu_pc_d    = alu_pc_q;
    alu_tag_d   = alu_tag_q;
    w1          = '0;
    w2          = '0;

    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
      count_d = '0;
      full_d  = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (entries_q[i].busy) begin
          w1 = snoop(entries_q[i].q1_busy, entries_q[i].q1, entries_q[i].v1,
                     cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                     cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
          w2 = snoop(entries_q[i].q2_busy, entries_q[i].q2, entries_q[i].v2,
                     cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                     cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
          entries_d[i].q1_busy = w1.busy;
          entries_d[i].v1      = w1.val;
          entries_d[i].q2_busy = w2.busy;
          entries_d[i].v2      = w2.val;
        end
      end

      if (ready_any) begin
        entries_d[ready_idx].busy = 1'b0;
        alu_valid_d = 1'b1;
        alu_op_d    = entries_q[ready_idx].op;
        alu_v1_d    = entries_q[ready_idx].v1;
        alu_v2_d    = entries_q[ready_idx].v2;
        alu_imm_d   = entries_q[ready_idx].imm;
        alu_pc_d    = entries_q[ready_idx].pc;
        alu_tag_d   = entries_q[ready_idx].tag;
      end

      // The free slot is never the issuing slot, so a slot freed this cycle is reusable only next edge.
      if (accept) begin
        entries_d[free_idx] = new_entry;
      end

      count_d = count_q + CNT_W'(accept) - CNT_W'(ready_any);
      full_d  = (count_d == CNT_W'(RS_SIZE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      count_q     <= '0;
      full_q      <= 1'b0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= OP_NOP;
      alu_v1_q    <= '0;
      alu_v2_q    <= '0;
      alu_imm_q   <= '0;
      alu_pc_q    <= '0;
      alu_tag_q   <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q     <= count_d;
      full_q      <= full_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_v1_q    <= alu_v1_d;
      alu_v2_q    <= alu_v2_d;
      alu_imm_q   <= alu_imm_d;
      alu_pc_q    <= alu_pc_d;
      alu_tag_q   <= alu_tag_d;
    end
  end

  assign full      = full_q;
  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_v1    = alu_v1_q;
  assign alu_v2    = alu_v2_q;
  assign alu_imm   = alu_imm_q;
  assign alu_pc    = alu_pc_q;
  assign alu_tag   = alu_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, issue, wakeup, bypass, full/priority, freeze and flush.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic              clk = 1'b0;
  logic              rst, rdy, flush;
  logic              disp_valid;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_imm, disp_pc, disp_v1, disp_v2;
  logic [TAG_W-1:0]  disp_tag, disp_q1, disp_q2;
  logic              disp_q1_busy, disp_q2_busy;
  logic              cdb_alu_valid, cdb_lsb_valid;
  logic [TAG_W-1:0]  cdb_alu_tag, cdb_lsb_tag;
  logic [DATA_W-1:0] cdb_alu_data, cdb_lsb_data;
  logic              full, alu_valid;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_v1, alu_v2, alu_imm, alu_pc;
  logic [TAG_W-1:0]  alu_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_tag(disp_tag), .disp_q1_busy(disp_q1_busy), .disp_q1(disp_q1), .disp_v1(disp_v1),
    .disp_q2_busy(disp_q2_busy), .disp_q2(disp_q2), .disp_v2(disp_v2),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_data(cdb_alu_data),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_data(cdb_lsb_data),
    .full(full), .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_tag(alu_tag)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    disp_valid = 1'b0; disp_op = OP_NOP; disp_imm = '0; disp_pc = '0; disp_tag = '0;
    disp_q1_busy = 1'b0; disp_q1 = '0; disp_v1 = '0;
    disp_q2_busy = 1'b0; disp_q2 = '0; disp_v2 = '0;
    cdb_alu_valid = 1'b0; cdb_alu_tag = '0; cdb_alu_data = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_tag = '0; cdb_lsb_data = '0;
    flush = 1'b0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                      input logic q1b, input logic [TAG_W-1:0] q1, input logic [DATA_W-1:0] v1,
                      input logic q2b, input logic [TAG_W-1:0] q2, input logic [DATA_W-1:0] v2,
                      input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc);
    disp_valid = 1'b1; disp_op = op; disp_tag = tag;
    disp_q1_busy = q1b; disp_q1 = q1; disp_v1 = v1;
    disp_q2_busy = q2b; disp_q2 = q2; disp_v2 = v2;
    disp_imm = imm; disp_pc = pc;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    clr_in();
    #3;
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_valid", 32'(alu_valid), 32'h0);
    chk("reset_op", 32'(alu_op), 32'(OP_NOP));
    chk("reset_v1", alu_v1, 32'h0);
    tick();
    rst = 1'b0;

    // Both operands ready: issued one edge after dispatch, strobe lasts one cycle.
    disp(OP_ADD, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'hFFF, 32'h100);
    tick(); clr_in();
    chk("add_no_issue_yet", 32'(alu_valid), 32'h0);
    tick();
    chk("add_valid", 32'(alu_valid), 32'h1);
    chk("add_op", 32'(alu_op), 32'(OP_ADD));
    chk("add_v1", alu_v1, 32'd5);
    chk("add_v2", alu_v2, 32'd7);
    chk("add_tag", 32'(alu_tag), 32'd3);
    chk("add_imm", alu_imm, 32'hFFF);
    chk("add_pc", alu_pc, 32'h100);
    tick();
    chk("add_valid_drop", 32'(alu_valid), 32'h0);
    chk("add_op_nop", 32'(alu_op), 32'(OP_NOP));
    chk("add_v1_hold", alu_v1, 32'd5);

    // Wakeup from the LSB CDB, issued one edge after the wakeup edge.
    disp(OP_SUB, 4'd4, 1'b1, 4'd6, 32'h0, 1'b0, 4'd0, 32'd3, 32'h0, 32'h104);
    tick(); clr_in();
    chk("wake_wait", 32'(alu_valid), 32'h0);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd6; cdb_lsb_data = 32'h10;
    tick(); clr_in();
    chk("wake_not_same_edge", 32'(alu_valid), 32'h0);
    tick();
    chk("wake_valid", 32'(alu_valid), 32'h1);
    chk("wake_op", 32'(alu_op), 32'(OP_SUB));
    chk("wake_v1", alu_v1, 32'h10);
    chk("wake_v2", alu_v2, 32'd3);
    chk("wake_tag", 32'(alu_tag), 32'd4);

    // Same-cycle bypass; ALU CDB beats LSB CDB on the same tag.
    disp(OP_ADD, 4'd5, 1'b0, 4'd0, 32'd1, 1'b1, 4'd2, 32'h0, 32'h0, 32'h108);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd2; cdb_alu_data = 32'd9;
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd2; cdb_lsb_data = 32'h77;
    tick(); clr_in();
    tick();
    chk("byp_valid", 32'(alu_valid), 32'h1);
    chk("byp_v2", alu_v2, 32'd9);
    chk("byp_tag", 32'(alu_tag), 32'd5);
    tick();

    // Fill all 16 slots with waiting entries; entry 2 waits on 10, entry 5 on 11, others on 15.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (i == 2)
        disp(OP_ADD, 4'(i), 1'b1, 4'd10, 32'h0, 1'b0, 4'd0, 32'h100 + 32'(i), 32'h0, 32'h200);
      else if (i == 5)
        disp(OP_ADD, 4'(i), 1'b0, 4'd0, 32'(i), 1'b1, 4'd11, 32'h0, 32'h0, 32'h200);
      else
        disp(OP_ADD, 4'(i), 1'b1, 4'd15, 32'h0, 1'b0, 4'd0, 32'h100 + 32'(i), 32'h0, 32'h200);
      tick();
      if (i == RS_SIZE - 2) chk("full_at_15", 32'(full), 32'h0);
    end
    clr_in();
    chk("full_at_16", 32'(full), 32'h1);
    disp(OP_ADD, 4'd14, 1'b0, 4'd0, 32'hEE, 1'b0, 4'd0, 32'hEE, 32'h0, 32'h300);
    tick(); clr_in();
    chk("drop_full", 32'(full), 32'h1);
    chk("drop_no_issue0", 32'(alu_valid), 32'h0);
    tick();
    chk("drop_no_issue1", 32'(alu_valid), 32'h0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd10; cdb_alu_data = 32'hA0;
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd11; cdb_lsb_data = 32'hB0;
    tick(); clr_in();
    chk("prio_wait", 32'(alu_valid), 32'h0);
    tick();
    chk("prio_first_valid", 32'(alu_valid), 32'h1);
    chk("prio_first_tag", 32'(alu_tag), 32'd2);
    chk("prio_first_v1", alu_v1, 32'hA0);
    chk("prio_first_v2", alu_v2, 32'h102);
    chk("prio_full_clear", 32'(full), 32'h0);
    tick();
    chk("prio_second_valid", 32'(alu_valid), 32'h1);
    chk("prio_second_tag", 32'(alu_tag), 32'd5);
    chk("prio_second_v1", alu_v1, 32'd5);
    chk("prio_second_v2", alu_v2, 32'hB0);
    tick();
    chk("prio_done", 32'(alu_valid), 32'h0);

    // Flush the 14 leftovers, then 4 busy entries flushed with a same-cycle dispatch and CDB.
    flush = 1'b1;
    tick(); clr_in();
    chk("flush1_full", 32'(full), 32'h0);
    for (int i = 0; i < 4; i++) begin
      disp(OP_SUB, 4'(i), 1'b1, 4'd15, 32'h0, 1'b0, 4'd0, 32'd1, 32'h0, 32'h400);
      tick();
    end
    clr_in();
    flush = 1'b1;
    disp(OP_ADD, 4'd8, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'h0, 32'h500);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd15; cdb_alu_data = 32'h1;
    tick(); clr_in();
    chk("flush2_valid", 32'(alu_valid), 32'h0);
    chk("flush2_op", 32'(alu_op), 32'(OP_NOP));
    chk("flush2_full", 32'(full), 32'h0);
    tick();
    chk("flush2_disp_discarded", 32'(alu_valid), 32'h0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd15; cdb_alu_data = 32'h1;
    tick(); clr_in();
    tick();
    chk("flush2_late_cdb0", 32'(alu_valid), 32'h0);
    tick();
    chk("flush2_late_cdb1", 32'(alu_valid), 32'h0);

    // rdy=0 ignores dispatch and freezes the outputs.
    rdy = 1'b0;
    disp(OP_ADD, 4'd7, 1'b0, 4'd0, 32'h70, 1'b0, 4'd0, 32'h71, 32'h0, 32'h600);
    tick(); clr_in();
    rdy = 1'b1;
    tick();
    chk("frz_disp_ignored", 32'(alu_valid), 32'h0);
    disp(OP_ADD, 4'd12, 1'b0, 4'd0, 32'h3C, 1'b0, 4'd0, 32'h0, 32'h0, 32'h700);
    tick(); clr_in();
    tick();
    chk("post_flush_issue", 32'(alu_valid), 32'h1);
    chk("post_flush_tag", 32'(alu_tag), 32'd12);
    rdy = 1'b0;
    tick();
    chk("frz_hold_valid", 32'(alu_valid), 32'h1);
    chk("frz_hold_tag", 32'(alu_tag), 32'd12);
    rdy = 1'b1;
    tick();
    chk("frz_release", 32'(alu_valid), 32'h0);

    // Asynchronous reset mid-cycle while an issue is on the outputs and an entry waits.
    disp(OP_SUB, 4'd9, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44, 32'h0, 32'h800);
    tick();
    disp(OP_ADD, 4'd10, 1'b1, 4'd13, 32'h0, 1'b0, 4'd0, 32'h1, 32'h0, 32'h804);
    tick(); clr_in();
    chk("arst_pre_valid", 32'(alu_valid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(alu_valid), 32'h0);
    chk("arst_op", 32'(alu_op), 32'(OP_NOP));
    chk("arst_v1", alu_v1, 32'h0);
    chk("arst_tag", 32'(alu_tag), 32'h0);
    chk("arst_full", 32'(full), 32'h0);
    #1;
    rst = 1'b0;
    tick();
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd13; cdb_lsb_data = 32'h5;
    tick(); clr_in();
    tick();
    chk("arst_entries_gone", 32'(alu_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
